// File: rtl/uart_debug_responder.sv
// Device-side responder for the UART debug preload protocol: decodes WRITE/READ/EXEC
// frames from the RX byte stream, drives a 32-bit memory request port, replies on TX.
module uart_debug_responder #(
   parameter int unsigned TimeoutCycles = 1000000,
   parameter logic [7:0]  AckByte       = 8'h06,
   parameter logic [7:0]  NakByte       = 8'h15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        req_o,
   input  logic        gnt_i,
   output logic [31:0] addr_o,
   output logic        we_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   input  logic        rvalid_i,
   input  logic [31:0] rdata_i,
   input  logic        err_i,
   output logic        exec_valid_o,
   output logic [31:0] exec_addr_o,
   output logic        busy_o
);

   localparam int unsigned TW = (TimeoutCycles > 32'd1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TW-1:0] TLast = (TimeoutCycles > 32'd0) ? TW'(TimeoutCycles - 32'd1) : '0;

   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_REQ    = 3'd3,
      S_WAIT_R = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   state_t         r_state, w_state;
   logic [1:0]     r_op, w_op;
   logic [1:0]     r_cnt, w_cnt;
   logic [31:0]    r_addr, w_addr, w_addr_shift;
   logic [31:0]    r_wdata, w_wdata, w_wdata_shift;
   logic [31:0]    r_tx_buf, w_tx_buf;
   logic [TW-1:0]  r_timer, w_timer;
   logic           r_rx_ready, w_rx_ready;
   logic           r_exec_valid, w_exec_valid;
   logic [31:0]    r_exec_addr, w_exec_addr;
   logic           w_rx_fire;
   logic           w_timeout;

   assign w_rx_fire = rx_valid_i & r_rx_ready;
   assign w_timeout = (TimeoutCycles != 32'd0) && (r_timer == TLast);

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_op         <= 2'd0;
         r_cnt        <= 2'd0;
         r_addr       <= 32'h0000_0000;
         r_wdata      <= 32'h0000_0000;
         r_tx_buf     <= 32'h0000_0000;
         r_timer      <= '0;
         r_rx_ready   <= 1'b0;
         r_exec_valid <= 1'b0;
         r_exec_addr  <= 32'h0000_0000;
      end else begin
         r_state      <= w_state;
         r_op         <= w_op;
         r_cnt        <= w_cnt;
         r_addr       <= w_addr;
         r_wdata      <= w_wdata;
         r_tx_buf     <= w_tx_buf;
         r_timer      <= w_timer;
         r_rx_ready   <= w_rx_ready;
         r_exec_valid <= w_exec_valid;
         r_exec_addr  <= w_exec_addr;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state       = r_state;
      w_op          = r_op;
      w_cnt         = r_cnt;
      w_addr        = r_addr;
      w_wdata       = r_wdata;
      w_tx_buf      = r_tx_buf;
      w_timer       = r_timer;
      w_exec_valid  = 1'b0;
      w_exec_addr   = r_exec_addr;
      w_addr_shift  = r_addr;
      w_addr_shift[{r_cnt, 3'b000} +: 8]  = rx_data_i;
      w_wdata_shift = r_wdata;
      w_wdata_shift[{r_cnt, 3'b000} +: 8] = rx_data_i;

      case (r_state)
         S_IDLE: begin
            if (w_rx_fire) begin
               if ((rx_data_i == 8'h01) || (rx_data_i == 8'h02) || (rx_data_i == 8'h03)) begin
                  w_op    = rx_data_i[1:0];
                  w_cnt   = 2'd0;
                  w_timer = '0;
                  w_state = S_ADDR;
               end else begin
                  w_tx_buf = {24'h00_0000, NakByte};
                  w_cnt    = 2'd0;
                  w_state  = S_RESP;
               end
            end else begin
               w_state = S_IDLE;
            end
         end
         S_ADDR: begin
            if (w_rx_fire) begin
               w_addr  = w_addr_shift;
               w_cnt   = r_cnt + 2'd1;
               w_timer = '0;
               if (r_cnt == 2'd3) begin
                  if (w_addr_shift[1:0] != 2'b00) begin
                     w_tx_buf = {24'h00_0000, NakByte};
                     w_cnt    = 2'd0;
                     w_state  = S_RESP;
                  end else if (r_op == OP_WRITE) begin
                     w_state = S_DATA;
                  end else if (r_op == OP_READ) begin
                     w_state = S_REQ;
                  end else begin
                     w_exec_valid = 1'b1;
                     w_exec_addr  = w_addr_shift;
                     w_tx_buf     = {24'h00_0000, AckByte};
                     w_cnt        = 2'd0;
                     w_state      = S_RESP;
                  end
               end else begin
                  w_state = S_ADDR;
               end
            end else if (w_timeout) begin
               w_state = S_IDLE;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end
         S_DATA: begin
            if (w_rx_fire) begin
               w_wdata = w_wdata_shift;
               w_cnt   = r_cnt + 2'd1;
               w_timer = '0;
               if (r_cnt == 2'd3) begin
                  w_state = S_REQ;
               end else begin
                  w_state = S_DATA;
               end
            end else if (w_timeout) begin
               w_state = S_IDLE;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end
         S_REQ: begin
            if (gnt_i) begin
               w_state = S_WAIT_R;
            end else begin
               w_state = S_REQ;
            end
         end
         S_WAIT_R: begin
            if (rvalid_i) begin
               w_state = S_RESP;
               if (err_i) begin
                  w_tx_buf = {24'h00_0000, NakByte};
                  w_cnt    = 2'd0;
               end else if (r_op == OP_WRITE) begin
                  w_tx_buf = {24'h00_0000, AckByte};
                  w_cnt    = 2'd0;
               end else begin
                  w_tx_buf = rdata_i;
                  w_cnt    = 2'd3;
               end
            end else begin
               w_state = S_WAIT_R;
            end
         end
         S_RESP: begin
            // r_cnt holds the number of bytes still to send after the current one
            if (tx_ready_i) begin
               if (r_cnt == 2'd0) begin
                  w_state = S_IDLE;
               end else begin
                  w_tx_buf = {8'h00, r_tx_buf[31:8]};
                  w_cnt    = r_cnt - 2'd1;
               end
            end else begin
               w_state = S_RESP;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_rx_ready = (w_state == S_IDLE) || (w_state == S_ADDR) || (w_state == S_DATA);
   end

   assign rx_ready_o   = r_rx_ready;
   assign tx_valid_o   = (r_state == S_RESP);
   assign tx_data_o    = r_tx_buf[7:0];
   assign req_o        = (r_state == S_REQ);
   assign we_o         = (r_state == S_REQ) && (r_op == OP_WRITE);
   assign addr_o       = {r_addr[31:2], 2'b00};
   assign wdata_o      = r_wdata;
   assign be_o         = 4'hF;
   assign exec_valid_o = r_exec_valid;
   assign exec_addr_o  = r_exec_addr;
   assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_debug_responder.sv
// Directed self-checking bench for uart_debug_responder (TimeoutCycles = 20).
module tb_uart_debug_responder;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        req_o;
   logic        gnt_i;
   logic [31:0] addr_o;
   logic        we_o;
   logic [31:0] wdata_o;
   logic [3:0]  be_o;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        err_i;
   logic        exec_valid_o;
   logic [31:0] exec_addr_o;
   logic        busy_o;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  tx_q[$];
   int          req_cnt = 0;
   int          exec_cnt = 0;

   always #5 clk_i = ~clk_i;

   uart_debug_responder #(
      .TimeoutCycles(20),
      .AckByte      (8'h06),
      .NakByte      (8'h15)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rx_data_i   (rx_data_i),
      .rx_valid_i  (rx_valid_i),
      .rx_ready_o  (rx_ready_o),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_ready_i  (tx_ready_i),
      .req_o       (req_o),
      .gnt_i       (gnt_i),
      .addr_o      (addr_o),
      .we_o        (we_o),
      .wdata_o     (wdata_o),
      .be_o        (be_o),
      .rvalid_i    (rvalid_i),
      .rdata_i     (rdata_i),
      .err_i       (err_i),
      .exec_valid_o(exec_valid_o),
      .exec_addr_o (exec_addr_o),
      .busy_o      (busy_o)
   );

   // Handshake monitor: TX bytes, granted requests, exec pulse cycles
   always @(posedge clk_i) begin
      if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
      if (req_o && gnt_i) req_cnt <= req_cnt + 1;
      if (exec_valid_o) exec_cnt <= exec_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      k = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      while (!rx_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      chk("rx_accept", {31'd0, rx_ready_o}, 32'd1);
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
   endtask

   task automatic send_seq(input logic [71:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*i +: 8]);
   endtask

   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (tx_q.size() < n && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      chk("tx_count", 32'(tx_q.size()), 32'(n));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ctl"}, {26'd0, rx_ready_o, tx_valid_o, req_o, we_o, exec_valid_o, busy_o}, 32'd0);
      chk({tag, "_txd"}, {24'd0, tx_data_o}, 32'd0);
      chk({tag, "_addr"}, addr_o, 32'd0);
      chk({tag, "_wdata"}, wdata_o, 32'd0);
      chk({tag, "_eaddr"}, exec_addr_o, 32'd0);
   endtask

   initial begin
      int good;
      int stable;
      int r0;
      int e0;
      logic [31:0] rd;

      rst_i = 1'b1; rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
      gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0; err_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset("rst0");
      chk("be_const", {28'd0, be_o}, 32'hF);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("idle_rx_ready", {31'd0, rx_ready_o}, 32'd1);

      // WRITE 0x1000_0000 <= 0xDEADBEEF
      tx_q.delete();
      send_seq(72'hDEADBEEF1000000001, 9);
      chk("wr_req", {31'd0, req_o}, 32'd1);
      chk("wr_addr", addr_o, 32'h1000_0000);
      chk("wr_we", {31'd0, we_o}, 32'd1);
      chk("wr_wdata", wdata_o, 32'hDEAD_BEEF);
      gnt_i = 1'b1;
      @(negedge clk_i);
      gnt_i = 1'b0;
      chk("wr_req_drop", {31'd0, req_o}, 32'd0);
      rvalid_i = 1'b1; err_i = 1'b0;
      @(negedge clk_i);
      rvalid_i = 1'b0;
      wait_tx(1);
      chk("wr_ack", {24'd0, tx_q[0]}, 32'h06);
      chk("wr_req_cnt", 32'(req_cnt), 32'd1);
      chk("wr_idle", {31'd0, busy_o}, 32'd0);

      // READ 0x1000_0004, grant delayed 5 cycles, TX stalled 3 cycles per byte
      tx_q.delete();
      tx_ready_i = 1'b0;
      send_seq(72'h1000000402, 5);
      good = 0;
      for (int i = 0; i < 6; i++) begin
         if (req_o === 1'b1 && addr_o === 32'h1000_0004 && we_o === 1'b0) good++;
         gnt_i = (i == 5);
         @(negedge clk_i);
      end
      gnt_i = 1'b0;
      chk("rd_req_stable", 32'(good), 32'd6);
      chk("rd_req_drop", {31'd0, req_o}, 32'd0);
      chk("rd_req_cnt", 32'(req_cnt), 32'd2);
      rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
      @(negedge clk_i);
      rvalid_i = 1'b0; rdata_i = 32'd0;
      rd = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         stable = 0;
         for (int j = 0; j < 3; j++) begin
            if (tx_valid_o === 1'b1 && tx_data_o === rd[8*i +: 8]) stable++;
            @(negedge clk_i);
         end
         chk("rd_stall_hold", 32'(stable), 32'd3);
         tx_ready_i = 1'b1;
         @(negedge clk_i);
         tx_ready_i = 1'b0;
      end
      tx_ready_i = 1'b1;
      chk("rd_tx_n", 32'(tx_q.size()), 32'd4);
      chk("rd_tx_bytes", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h1234_5678);
      chk("rd_idle", {31'd0, busy_o}, 32'd0);

      // EXEC 0x8000_0000
      tx_q.delete();
      r0 = req_cnt; e0 = exec_cnt;
      send_seq(72'h8000000003, 5);
      chk("ex_pulse", {31'd0, exec_valid_o}, 32'd1);
      chk("ex_addr", exec_addr_o, 32'h8000_0000);
      wait_tx(1);
      chk("ex_ack", {24'd0, tx_q[0]}, 32'h06);
      @(negedge clk_i);
      chk("ex_width", 32'(exec_cnt - e0), 32'd1);
      chk("ex_no_req", 32'(req_cnt), 32'(r0));
      chk("ex_addr_hold", exec_addr_o, 32'h8000_0000);

      // Unknown opcode
      tx_q.delete();
      send_seq(72'h7F, 1);
      wait_tx(1);
      chk("bad_op_nak", {24'd0, tx_q[0]}, 32'h15);
      chk("bad_op_idle", {31'd0, busy_o}, 32'd0);

      // Misaligned address
      tx_q.delete();
      r0 = req_cnt;
      send_seq(72'h1000000201, 5);
      chk("mis_no_req", {31'd0, req_o}, 32'd0);
      wait_tx(1);
      chk("mis_nak", {24'd0, tx_q[0]}, 32'h15);
      chk("mis_req_cnt", 32'(req_cnt), 32'(r0));

      // READ with error response; grant arrives in the cycle req rises
      tx_q.delete();
      send_seq(72'h00000002, 4);
      gnt_i = 1'b1;
      send_byte(8'h10);
      chk("err_req", {31'd0, req_o}, 32'd1);
      @(negedge clk_i);
      gnt_i = 1'b0;
      chk("err_req_drop", {31'd0, req_o}, 32'd0);
      rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'h5555_AAAA;
      @(negedge clk_i);
      rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'd0;
      wait_tx(1);
      chk("err_nak", {24'd0, tx_q[0]}, 32'h15);
      chk("err_tx_n", 32'(tx_q.size()), 32'd1);

      // Inter-byte timeout, then a fresh READ
      tx_q.delete();
      send_seq(72'h000001, 3);
      repeat (19) @(negedge clk_i);
      chk("to_busy_19", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
      chk("to_busy_20", {31'd0, busy_o}, 32'd0);
      chk("to_rx_ready", {31'd0, rx_ready_o}, 32'd1);
      repeat (3) @(negedge clk_i);
      chk("to_no_tx", 32'(tx_q.size()), 32'd0);
      send_seq(72'h1000000002, 5);
      chk("to_rd_req", {31'd0, req_o}, 32'd1);
      chk("to_rd_addr", addr_o, 32'h1000_0000);
      chk("to_rd_we", {31'd0, we_o}, 32'd0);
      gnt_i = 1'b1;
      @(negedge clk_i);
      gnt_i = 1'b0;
      rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
      @(negedge clk_i);
      rvalid_i = 1'b0; rdata_i = 32'd0;
      wait_tx(4);
      chk("to_rd_bytes", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'hCAFE_F00D);

      // Reset while waiting for the read response
      tx_q.delete();
      send_seq(72'h1000000802, 5);
      gnt_i = 1'b1;
      @(negedge clk_i);
      gnt_i = 1'b0;
      chk("rw_busy", {31'd0, busy_o}, 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_reset("rst_wait");
      rst_i = 1'b0;
      rvalid_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      rvalid_i = 1'b0; rdata_i = 32'd0;
      repeat (10) @(negedge clk_i);
      chk("rw_no_tx", 32'(tx_q.size()), 32'd0);
      chk("rw_idle", {31'd0, busy_o}, 32'd0);
      chk("rw_rx_ready", {31'd0, rx_ready_o}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
